// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants, depth/pointer helpers and flag struct for
//                the single-clock FIFO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEF_DATA_SIZE = 8;
    localparam int c_DEF_ADDR_SIZE = 4;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // One extra MSB beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    localparam int c_DEF_DEPTH        = fifo_depth(c_DEF_ADDR_SIZE);
    localparam int c_DEF_PTR_WIDTH    = ptr_width(c_DEF_ADDR_SIZE);
    localparam int c_DEF_AFULL_LEVEL  = c_DEF_DEPTH - 2;
    localparam int c_DEF_AEMPTY_LEVEL = 2;

    typedef struct packed {
        logic wfull;
        logic walmost_full;
        logic rempty;
        logic ralmost_empty;
    } fifo_flags_t;

    // Status flags for a given occupancy; evaluated on the next-cycle count.
    function automatic fifo_flags_t fifo_flags(
        input int count,
        input int depth,
        input int afull_level,
        input int aempty_level
    );
        fifo_flags_t f;
        f.wfull         = (count == depth);
        f.walmost_full  = (count >= afull_level);
        f.rempty        = (count == 0);
        f.ralmost_empty = (count <= aempty_level);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ctrl_if
//  Description : Producer/consumer bus of the single-clock FIFO. The master
//                side drives requests, the slave (FIFO) side returns status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = c_DEF_DATA_SIZE,
    parameter int ADDR_SIZE = c_DEF_ADDR_SIZE
);

    logic                  flush;
    logic                  winc;
    logic [DATA_SIZE-1:0]  wdata;
    logic                  wfull;
    logic                  walmost_full;
    logic                  rinc;
    logic [DATA_SIZE-1:0]  rdata;
    logic                  rvalid;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_SIZE:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush,
        output winc,
        output wdata,
        output rinc,
        input  wfull,
        input  walmost_full,
        input  rdata,
        input  rvalid,
        input  rempty,
        input  ralmost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  flush,
        input  winc,
        input  wdata,
        input  rinc,
        output wfull,
        output walmost_full,
        output rdata,
        output rvalid,
        output rempty,
        output ralmost_empty,
        output count,
        output overflow,
        output underflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_dpram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_dpram
//  Description : Simple dual-port FIFO storage, one write port and one
//                registered read port. The array itself is never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = c_DEF_DATA_SIZE,
    parameter int ADDR_SIZE = c_DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_raddr,
    output logic [DATA_SIZE-1:0] o_rdata
);

    localparam int c_DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] r_mem [c_DEPTH];
    logic [DATA_SIZE-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-address write in this cycle is not forwarded: old data is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ctrl
//  Description : Single-clock FIFO: pointers, occupancy, registered flags,
//                synchronous flush and sticky overflow/underflow errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE    = c_DEF_DATA_SIZE,
    parameter int ADDR_SIZE    = c_DEF_ADDR_SIZE,
    parameter int AFULL_LEVEL  = fifo_depth(ADDR_SIZE) - 2,
    parameter int AEMPTY_LEVEL = c_DEF_AEMPTY_LEVEL
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_ctrl_if.slave bus
);

    localparam int                 c_DEPTH   = fifo_depth(ADDR_SIZE);
    localparam int                 c_PTR_W   = ptr_width(ADDR_SIZE);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam fifo_flags_t        c_FLAGS_CLEAR =
        fifo_flags(0, c_DEPTH, AFULL_LEVEL, AEMPTY_LEVEL);

    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W-1:0]   r_count;
    fifo_flags_t          r_flags;
    logic                 r_overflow;
    logic                 r_underflow;
    logic                 r_rvalid;

    logic                 w_do_read;
    logic                 w_do_write;
    logic                 w_read_en;
    logic                 w_write_en;
    logic [c_PTR_W-1:0]   w_count_next;
    fifo_flags_t          w_flags_next;
    logic [DATA_SIZE-1:0] w_rdata;

    // A write into a full FIFO is legal only when a read frees a slot in the
    // same cycle; a read from an empty FIFO never borrows the incoming word.
    always_comb begin
        w_do_read    = bus.rinc && !r_flags.rempty;
        w_do_write   = bus.winc && (!r_flags.wfull || w_do_read);
        w_read_en    = w_do_read  && !bus.flush;
        w_write_en   = w_do_write && !bus.flush;
        w_count_next = r_count
                     + (w_write_en ? c_PTR_ONE : '0)
                     - (w_read_en  ? c_PTR_ONE : '0);
        w_flags_next = fifo_flags(int'(w_count_next), c_DEPTH,
                                  AFULL_LEVEL, AEMPTY_LEVEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_flags     <= c_FLAGS_CLEAR;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rvalid    <= 1'b0;
        end else if (bus.flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_flags     <= c_FLAGS_CLEAR;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            if (w_write_en) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_read_en) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count  <= w_count_next;
            r_flags  <= w_flags_next;
            r_rvalid <= w_read_en;
            if (bus.winc && !w_do_write) begin
                r_overflow <= 1'b1;
            end
            if (bus.rinc && !w_do_read) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_dpram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_dpram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_write_en),
        .i_waddr (r_wptr[ADDR_SIZE-1:0]),
        .i_wdata (bus.wdata),
        .i_re    (w_read_en),
        .i_raddr (r_rptr[ADDR_SIZE-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.rdata         = w_rdata;
    assign bus.rvalid        = r_rvalid;
    assign bus.count         = r_count;
    assign bus.wfull         = r_flags.wfull;
    assign bus.walmost_full  = r_flags.walmost_full;
    assign bus.rempty        = r_flags.rempty;
    assign bus.ralmost_empty = r_flags.ralmost_empty;
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_ctrl
//  Description : Directed self-checking bench for sync_fifo_ctrl with a
//                contents model and an expected-read-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;
    localparam int AEMPT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    sync_fifo_ctrl #(
        .DATA_SIZE    (DW),
        .ADDR_SIZE    (AW),
        .AFULL_LEVEL  (AFULL),
        .AEMPTY_LEVEL (AEMPT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mdl[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_rd;
    bit            m_ovf, m_unf, m_rv;
    int            n_checks, n_pass, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int c;
        c = mdl.size();
        chk($sformatf("%s.count", tag),     32'(bus.count),         32'(c));
        chk($sformatf("%s.wfull", tag),     32'(bus.wfull),         32'(c == DEPTH));
        chk($sformatf("%s.afull", tag),     32'(bus.walmost_full),  32'(c >= AFULL));
        chk($sformatf("%s.rempty", tag),    32'(bus.rempty),        32'(c == 0));
        chk($sformatf("%s.aempty", tag),    32'(bus.ralmost_empty), 32'(c <= AEMPT));
        chk($sformatf("%s.overflow", tag),  32'(bus.overflow),      32'(m_ovf));
        chk($sformatf("%s.underflow", tag), 32'(bus.underflow),     32'(m_unf));
        chk($sformatf("%s.rvalid", tag),    32'(bus.rvalid),        32'(m_rv));
        if (m_rv) begin
            if (sb.size() > 0) begin
                last_rd = sb.pop_front();
                chk($sformatf("%s.rdata", tag), 32'(bus.rdata), 32'(last_rd));
            end else begin
                chk($sformatf("%s.sb_underrun", tag), 32'(1), 32'(0));
            end
        end
    endtask

    // Drive one clock of requests, advance the model, then check after the edge.
    task automatic cycle(input string tag, input bit w, input bit r,
                         input logic [DW-1:0] d, input bit f);
        bit do_r, do_w;
        bus.winc  = w;
        bus.rinc  = r;
        bus.wdata = d;
        bus.flush = f;
        if (f) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            do_r = r && (mdl.size() > 0);
            do_w = w && ((mdl.size() < DEPTH) || do_r);
            if (w && !do_w) m_ovf = 1'b1;
            if (r && !do_r) m_unf = 1'b1;
            if (do_r) sb.push_back(mdl.pop_front());
            if (do_w) mdl.push_back(d);
            m_rv = do_r;
        end
        @(posedge clk);
        #1;
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.flush = 1'b0;
        check_state(tag);
    endtask

    task automatic reset_check(input string tag);
        chk($sformatf("%s.count", tag),     32'(bus.count),         32'(0));
        chk($sformatf("%s.rempty", tag),    32'(bus.rempty),        32'(1));
        chk($sformatf("%s.aempty", tag),    32'(bus.ralmost_empty), 32'(1));
        chk($sformatf("%s.wfull", tag),     32'(bus.wfull),         32'(0));
        chk($sformatf("%s.afull", tag),     32'(bus.walmost_full),  32'(0));
        chk($sformatf("%s.rdata", tag),     32'(bus.rdata),         32'(0));
        chk($sformatf("%s.rvalid", tag),    32'(bus.rvalid),        32'(0));
        chk($sformatf("%s.overflow", tag),  32'(bus.overflow),      32'(0));
        chk($sformatf("%s.underflow", tag), 32'(bus.underflow),     32'(0));
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; last_rd = '0;
        bus.flush = 1'b0; bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 reset_check("init");
        @(negedge clk) rst_n = 1'b1;

        // Reset asserted asynchronously mid-operation
        cycle("pre_w0", 1, 0, 8'h11, 0);
        cycle("pre_w1", 1, 0, 8'h22, 0);
        cycle("pre_w2", 1, 0, 8'h33, 0);
        cycle("pre_r0", 0, 1, 8'h00, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 reset_check("t1_reset");
        mdl.delete(); sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; last_rd = '0;
        @(negedge clk) rst_n = 1'b1;

        // Fill, reject one write, drain
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("t2_w%0d", i), 1, 0, 8'(i), 0);
        cycle("t2_wover", 1, 0, 8'h99, 0);
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("t2_r%0d", i), 0, 1, 8'h00, 0);

        // Full with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("t3_w%0d", i), 1, 0, 8'(8'h20 + i), 0);
        cycle("t3_wr_full", 1, 1, 8'hAA, 0);
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("t3_r%0d", i), 0, 1, 8'h00, 0);

        // Empty with simultaneous write and read
        cycle("t4_wr_empty", 1, 1, 8'h55, 0);
        cycle("t4_r", 0, 1, 8'h00, 0);

        // Streaming at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) cycle($sformatf("t5_pre%0d", i), 1, 0, 8'(8'h30 + i), 0);
        for (int i = 0; i < 40; i++) cycle($sformatf("t5_s%0d", i), 1, 1, 8'(8'h40 + i), 0);

        // Flush at count 9 with overflow set, competing write ignored
        for (int i = 0; i < 6; i++) cycle($sformatf("t6_w%0d", i), 1, 0, 8'(8'h70 + i), 0);
        chk("t6.ovf_pre", 32'(bus.overflow), 32'(1));
        cycle("t6_flush", 1, 0, 8'h77, 1);
        chk("t6.rdata_hold", 32'(bus.rdata), 32'(last_rd));
        cycle("t6_w_after", 1, 0, 8'h66, 0);
        cycle("t6_r_after", 0, 1, 8'h00, 0);
        cycle("t6_r_empty", 0, 1, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
